pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Central pipeline controller for the rv5stage core. It collects the stall and flush requests that each of the five stages (IF, ID, EX, MEM, WB) raises, detects load-use hazards between decode and execute, and drives every stage's control input. Downstream bubbles are inserted on repeated stall cycles, so a held stage output is never consumed twice. It also keeps stall/flush performance counters and a stall watchdog.

## Interface
Parameters:
- `STALL_LIMIT`, default 1024: number of consecutive stalled cycles after which `hang` sets.
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_if`, `req_id`, `req_ex`, `req_mem`, `req_wb`  in  PipeRequest each  per-stage `{stall_req, flush_req[3:0]}`.
- `dec_info`  in  DecodeInfo  instruction currently being decoded (IF output register).
- `exe_info`  in  DecodeInfo  instruction currently in EX (ID output register).
- `pipe_if`, `pipe_id`, `pipe_ex`, `pipe_mem`, `pipe_wb`  out  PipeControl each  per-stage `{stall, flush}`.
- `stall_cycles`  out  CNT_W  count of cycles with any stall asserted.
- `flush_events`  out  CNT_W  count of cycles with any request-driven flush.
- `lu_hazards`  out  CNT_W  count of load-use bubbles inserted.
- `hang`  out  1  sticky watchdog flag.

## Operation
- Stage index: IF=0, ID=1, EX=2, MEM=3, WB=4. Bit `flush_req[j]` targets the output register of stage j, for j = 0..3.
- **Load-use (`lu`).** Asserted when all of the following hold:
  - `dec_info.enable` and `exe_info.enable`;
  - `exe_info.mem_read` and `exe_info.rd_valid` and `exe_info.rd != 0`;
  - `(dec_info.rs1_valid && dec_info.rs1 == exe_info.rd) || (dec_info.rs2_valid && dec_info.rs2 == exe_info.rd)`.
- **Stall.** `stall[j]` is the OR of `stall_req` from stages k >= j. Load-use additionally forces `stall[0]`.
- **Request flush.** `rflush[j]` is the OR over stages k of `req_k.flush_req[j] && !stall[k]`. A stalled requester's flush is ignored.
- **Bubble insertion.** `held[k]` is a register holding `stall[k]` as applied at the last edge. `bubble[j]`, for j = 1..4, is `stall[j-1] && held[j-1] && !stall[j]`.
- **Load-use bubble.** Load-use also forces `flush[1]` in the same cycle: IF holds the consumer and ID's output becomes a bubble. This lasts one cycle only; the hazard clears because `exe_info` becomes the bubble.
- **Outputs.** `pipe_j.flush = rflush[j] | bubble[j] | (j==1 & lu)` and `pipe_j.stall = stall[j]`. Flush has priority inside each stage. Stall never depends on flush, so there is no combinational loop.
- **Counters.** All counters wrap at 2^CNT_W.
  - `stall_cycles` increments on any `stall[j]`.
  - `flush_events` increments on any `rflush[j]`.
  - `lu_hazards` increments on `lu`.
- **Watchdog.** A consecutive-stall counter increments while `stall[0]` and clears otherwise. It saturates at STALL_LIMIT, where `hang` sets. `hang` clears only on reset.

## Timing
- The `pipe_*` outputs are combinational from the current requests and the `held` register: zero latency.
- `held`, the counters and `hang` update on the rising edge.
- Stall held for N cycles at stage k: stage k+1 is flushed in cycles 2..N and not in cycle 1.
- EX redirect (`flush_req = 0111`) while MEM stalls: the redirect is ignored, EX is stalled, and EX re-requests once the stall is released.
- Simultaneous load-use and EX redirect:
  - `flush[0]` and `flush[1]` both assert;
  - `stall[0]` also asserts, but flush wins in IF.
- Reset, including mid-stall:
  - `held`, all counters and `hang` clear to 0 asynchronously.
  - While `rst` is high, all `pipe_*` outputs are 0.
  - On the first cycle after reset no bubbles are generated.

## Structure
- PipeRequest, PipeControl and DecodeInfo stay in the shared `common.sv` package.
- Add `STAGE_IF`..`STAGE_WB` and `NUM_STAGES = 5` to `common.sv`.
- One natural sub-module: `load_use_detect`, combinational, with inputs `dec_info` and `exe_info` and output `lu`.
- Counters and watchdog stay inline.

## Test plan
- **Load-use.** `exe_info` = {mem_read, rd=5}, `dec_info` = {rs1=5}, for one cycle → `pipe_if.stall=1`, `pipe_id.flush=1`, `lu_hazards` goes 0→1. Next cycle `exe_info` is a bubble → all controls 0.
- **Load-use to x0.** Same as above but rd=0, or rs valid bits clear → no stall, no flush, counter unchanged.
- **MEM stall for 3 cycles.**
  - `stall[0..3]` = 1 for 3 cycles.
  - `pipe_wb.flush` = 0, 1, 1 across those cycles.
  - `stall_cycles` = 3 afterwards.
- **Redirect.**
  - `req_ex.flush_req=0111` with no stall → `pipe_if`, `pipe_id`, `pipe_ex` flush=1, `flush_events`=1.
  - Repeat with `req_mem.stall_req=1` → no flush.
- **Watchdog.** `STALL_LIMIT=4` and `req_wb.stall_req` held for 4 cycles → `hang` rises after the 4th edge and stays 1 after the stall drops.
- **Reset mid-stall.** Assert `rst` asynchronously during cycle 2 of an ID stall → `held`, counters and `hang` read 0 immediately; first post-reset cycle has no bubble.

Source files
------------

// File: rtl/common.sv
// rtl/common.sv - shared rv5stage pipeline types and stage indices.
package common;

  localparam int STAGE_IF   = 0;
  localparam int STAGE_ID   = 1;
  localparam int STAGE_EX   = 2;
  localparam int STAGE_MEM  = 3;
  localparam int STAGE_WB   = 4;
  localparam int NUM_STAGES = 5;

  typedef struct packed {
    logic       stall_req;
    logic [3:0] flush_req;
  } PipeRequest;

  typedef struct packed {
    logic stall;
    logic flush;
  } PipeControl;

  typedef struct packed {
    logic       enable;
    logic       mem_read;
    logic       rd_valid;
    logic [4:0] rd;
    logic       rs1_valid;
    logic [4:0] rs1;
    logic       rs2_valid;
    logic [4:0] rs2;
  } DecodeInfo;

  function automatic PipeControl make_ctrl(input logic stall, input logic flush);
    return '{stall: stall, flush: flush};
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - flags a decode source that needs a load still in EX.
module load_use_detect
  import common::*;
(
  input  DecodeInfo dec_info,
  input  DecodeInfo exe_info,
  output logic      lu
);

  logic producer;
  logic consumer;

  // x0 is hardwired zero, so a load into it never creates a dependency
  assign producer = exe_info.enable && exe_info.mem_read && exe_info.rd_valid &&
                    (exe_info.rd != 5'd0);
  assign consumer = (dec_info.rs1_valid && (dec_info.rs1 == exe_info.rd)) ||
                    (dec_info.rs2_valid && (dec_info.rs2 == exe_info.rd));
  assign lu = dec_info.enable && producer && consumer;

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - rv5stage stall/flush arbitration, bubbles, perf counters, watchdog.
module pipe_ctrl
  import common::*;
#(
  parameter int STALL_LIMIT = 1024,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  PipeRequest       req_if,
  input  PipeRequest       req_id,
  input  PipeRequest       req_ex,
  input  PipeRequest       req_mem,
  input  PipeRequest       req_wb,
  input  DecodeInfo        dec_info,
  input  DecodeInfo        exe_info,
  output PipeControl       pipe_if,
  output PipeControl       pipe_id,
  output PipeControl       pipe_ex,
  output PipeControl       pipe_mem,
  output PipeControl       pipe_wb,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic [CNT_W-1:0] lu_hazards,
  output logic             hang
);

  localparam int RUN_W = $clog2(STALL_LIMIT + 1);
  localparam logic [RUN_W-1:0] RUN_LIM = RUN_W'(STALL_LIMIT);
  localparam logic [RUN_W-1:0] RUN_PRE = RUN_W'(STALL_LIMIT - 1);

  PipeRequest            req [NUM_STAGES];
  logic                  lu;
  logic                  acc;
  logic [NUM_STAGES-1:0] stall;
  logic [NUM_STAGES-1:0] rflush;
  logic [NUM_STAGES-1:0] bubble;
  logic [NUM_STAGES-1:0] flush;
  logic [3:0]            held;
  logic [RUN_W-1:0]      run_cnt;

  assign req[STAGE_IF]  = req_if;
  assign req[STAGE_ID]  = req_id;
  assign req[STAGE_EX]  = req_ex;
  assign req[STAGE_MEM] = req_mem;
  assign req[STAGE_WB]  = req_wb;

  load_use_detect u_lu (
    .dec_info (dec_info),
    .exe_info (exe_info),
    .lu       (lu)
  );

  always_comb begin
    acc    = 1'b0;
    stall  = '0;
    rflush = '0;
    bubble = '0;
    for (int j = NUM_STAGES - 1; j >= 0; j--) begin
      acc      = acc | req[j].stall_req;
      stall[j] = acc;
    end
    stall[STAGE_IF] = stall[STAGE_IF] | lu;
    // a stalled requester may be acting on stale state, so its flush is dropped
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        if (req[k].flush_req[j] && !stall[k]) rflush[j] = 1'b1;
      end
    end
    for (int j = 1; j < NUM_STAGES; j++) begin
      bubble[j] = stall[j-1] & held[j-1] & ~stall[j];
    end
    flush = rflush | bubble;
    flush[STAGE_ID] = flush[STAGE_ID] | lu;
  end

  assign pipe_if  = rst ? PipeControl'('0) : make_ctrl(stall[STAGE_IF],  flush[STAGE_IF]);
  assign pipe_id  = rst ? PipeControl'('0) : make_ctrl(stall[STAGE_ID],  flush[STAGE_ID]);
  assign pipe_ex  = rst ? PipeControl'('0) : make_ctrl(stall[STAGE_EX],  flush[STAGE_EX]);
  assign pipe_mem = rst ? PipeControl'('0) : make_ctrl(stall[STAGE_MEM], flush[STAGE_MEM]);
  assign pipe_wb  = rst ? PipeControl'('0) : make_ctrl(stall[STAGE_WB],  flush[STAGE_WB]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held         <= '0;
      stall_cycles <= '0;
      flush_events <= '0;
      lu_hazards   <= '0;
      run_cnt      <= '0;
      hang         <= 1'b0;
    end else begin
      held <= stall[3:0];
      if (|stall)  stall_cycles <= stall_cycles + 1'b1;
      if (|rflush) flush_events <= flush_events + 1'b1;
      if (lu)      lu_hazards   <= lu_hazards + 1'b1;
      if (stall[STAGE_IF]) begin
        if (run_cnt != RUN_LIM) run_cnt <= run_cnt + 1'b1;
        if (run_cnt >= RUN_PRE) hang <= 1'b1;
      end else begin
        run_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard bench for pipe_ctrl: directed cases then random traffic.
module tb_pipe_ctrl;
  import common::*;

  localparam int LIMIT = 4;
  localparam int CW    = 8;

  typedef struct {
    int         idx;
    bit [4:0]   st;
    bit [4:0]   fl;
    int         sc;
    int         fe;
    int         lh;
    bit         hg;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  PipeRequest req_if, req_id, req_ex, req_mem, req_wb;
  DecodeInfo  dec_info, exe_info;
  PipeControl pipe_if, pipe_id, pipe_ex, pipe_mem, pipe_wb;
  logic [CW-1:0] stall_cycles, flush_events, lu_hazards;
  logic hang;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   vec_idx = 0;

  int       m_sc = 0, m_fe = 0, m_lh = 0, m_run = 0;
  bit       m_hang = 0;
  bit [4:0] m_prev = '0;

  always #5 clk = ~clk;

  pipe_ctrl #(.STALL_LIMIT(LIMIT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req_if(req_if), .req_id(req_id), .req_ex(req_ex), .req_mem(req_mem), .req_wb(req_wb),
    .dec_info(dec_info), .exe_info(exe_info),
    .pipe_if(pipe_if), .pipe_id(pipe_id), .pipe_ex(pipe_ex), .pipe_mem(pipe_mem), .pipe_wb(pipe_wb),
    .stall_cycles(stall_cycles), .flush_events(flush_events), .lu_hazards(lu_hazards),
    .hang(hang)
  );

  function automatic DecodeInfo mk_exe(input bit en, input bit mr, input bit [4:0] rd);
    DecodeInfo d = '0;
    d.enable = en; d.mem_read = mr; d.rd_valid = 1'b1; d.rd = rd;
    return d;
  endfunction

  function automatic DecodeInfo mk_dec(input bit v1, input bit [4:0] r1, input bit v2, input bit [4:0] r2);
    DecodeInfo d = '0;
    d.enable = 1'b1; d.rs1_valid = v1; d.rs1 = r1; d.rs2_valid = v2; d.rs2 = r2;
    return d;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] want);
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s vec %0d: got %0h expected %0h", nm, idx, act, want);
    end
  endtask

  // Drive one cycle of stimulus; the reference model predicts outputs from the spec rules.
  task automatic apply(input bit [4:0] sreq, input bit [19:0] freq,
                       input DecodeInfo d, input DecodeInfo e, input bit r);
    exp_t     x;
    bit       lu;
    int       deepest;
    bit [4:0] st, rf, bub;
    @(posedge clk);
    #1;
    rst      = r;
    req_if   = '{stall_req: sreq[0], flush_req: freq[3:0]};
    req_id   = '{stall_req: sreq[1], flush_req: freq[7:4]};
    req_ex   = '{stall_req: sreq[2], flush_req: freq[11:8]};
    req_mem  = '{stall_req: sreq[3], flush_req: freq[15:12]};
    req_wb   = '{stall_req: sreq[4], flush_req: freq[19:16]};
    dec_info = d;
    exe_info = e;

    lu = d.enable && e.enable && e.mem_read && e.rd_valid && e.rd != 0 &&
         ((d.rs1_valid && d.rs1 == e.rd) || (d.rs2_valid && d.rs2 == e.rd));
    deepest = -1;
    for (int k = 0; k < 5; k++) if (sreq[k]) deepest = k;
    st = '0;
    for (int j = 0; j < 5; j++) st[j] = (j <= deepest);
    if (lu) st[0] = 1'b1;
    rf = '0;
    for (int k = 0; k < 5; k++) if (!st[k]) rf[3:0] = rf[3:0] | freq[4*k +: 4];
    bub = '0;
    for (int j = 1; j < 5; j++) bub[j] = st[j-1] && m_prev[j-1] && !st[j];

    x.idx = vec_idx++;
    if (r) begin
      x.st = '0; x.fl = '0; x.sc = 0; x.fe = 0; x.lh = 0; x.hg = 0;
      m_sc = 0; m_fe = 0; m_lh = 0; m_run = 0; m_hang = 0; m_prev = '0;
    end else begin
      x.st = st;
      x.fl = rf | bub | (lu ? 5'b00010 : 5'b0);
      x.sc = m_sc; x.fe = m_fe; x.lh = m_lh; x.hg = m_hang;
      m_prev = st;
      m_sc = (m_sc + (st != 0)) % (1 << CW);
      m_fe = (m_fe + (rf != 0)) % (1 << CW);
      m_lh = (m_lh + lu) % (1 << CW);
      m_run = st[0] ? m_run + 1 : 0;
      if (m_run >= LIMIT) m_hang = 1;
    end
    exp_q.push_back(x);
  endtask

  // Monitor: every presented cycle is compared against the oldest prediction.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        vectors++;
        chk("stall", x.idx, {pipe_wb.stall, pipe_mem.stall, pipe_ex.stall, pipe_id.stall, pipe_if.stall}, x.st);
        chk("flush", x.idx, {pipe_wb.flush, pipe_mem.flush, pipe_ex.flush, pipe_id.flush, pipe_if.flush}, x.fl);
        chk("stall_cycles", x.idx, stall_cycles, x.sc);
        chk("flush_events", x.idx, flush_events, x.fe);
        chk("lu_hazards", x.idx, lu_hazards, x.lh);
        chk("hang", x.idx, hang, x.hg);
      end
    end
  end

  initial begin
    DecodeInfo nd = '0;
    DecodeInfo d, e;
    req_if = '0; req_id = '0; req_ex = '0; req_mem = '0; req_wb = '0;
    dec_info = '0; exe_info = '0;

    apply(5'b0, 20'h0, nd, nd, 1'b1);
    apply(5'b0, 20'h0, nd, nd, 1'b0);
    // load-use, then bubble in EX
    apply(5'b0, 20'h0, mk_dec(1, 5, 0, 0), mk_exe(1, 1, 5), 1'b0);
    apply(5'b0, 20'h0, mk_dec(1, 5, 0, 0), nd, 1'b0);
    apply(5'b0, 20'h0, mk_dec(0, 0, 1, 7), mk_exe(1, 1, 7), 1'b0);
    apply(5'b0, 20'h0, nd, nd, 1'b0);
    // x0 and invalid-source cases
    apply(5'b0, 20'h0, mk_dec(1, 0, 1, 0), mk_exe(1, 1, 0), 1'b0);
    apply(5'b0, 20'h0, mk_dec(0, 5, 0, 5), mk_exe(1, 1, 5), 1'b0);
    apply(5'b0, 20'h0, mk_dec(1, 5, 0, 0), mk_exe(1, 0, 5), 1'b0);
    // MEM stall for 3 cycles
    repeat (3) apply(5'b01000, 20'h0, nd, nd, 1'b0);
    apply(5'b0, 20'h0, nd, nd, 1'b0);
    // EX redirect, free then blocked by MEM stall
    apply(5'b0, 20'h00700, nd, nd, 1'b0);
    apply(5'b01000, 20'h00700, nd, nd, 1'b0);
    apply(5'b0, 20'h00700, nd, nd, 1'b0);
    // load-use together with EX redirect
    apply(5'b0, 20'h00700, mk_dec(0, 0, 1, 9), mk_exe(1, 1, 9), 1'b0);
    apply(5'b0, 20'h0, nd, nd, 1'b0);
    // watchdog
    repeat (4) apply(5'b10000, 20'h0, nd, nd, 1'b0);
    repeat (2) apply(5'b0, 20'h0, nd, nd, 1'b0);
    // reset during cycle 2 of an ID stall
    apply(5'b00010, 20'h0, nd, nd, 1'b0);
    apply(5'b00010, 20'h0, nd, nd, 1'b1);
    apply(5'b00010, 20'h0, nd, nd, 1'b0);
    apply(5'b0, 20'h0, nd, nd, 1'b0);

    for (int i = 0; i < 500; i++) begin
      bit [4:0]  s = '0;
      bit [19:0] f = '0;
      for (int k = 0; k < 5; k++) begin
        s[k] = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 7) == 0) f[4*k +: 4] = 4'($urandom);
      end
      d = DecodeInfo'($urandom);
      e = DecodeInfo'($urandom);
      d.rs1 = 5'($urandom_range(0, 3));
      d.rs2 = 5'($urandom_range(0, 3));
      e.rd  = 5'($urandom_range(0, 3));
      apply(s, f, d, e, ($urandom_range(0, 59) == 0));
    end

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
